// File: rtl/arith_pkg.sv
// Shared constants for the calculator display path: seven-segment patterns
// (active-low, bit order {g,f,e,d,c,b,a}), formatter states and LED indices.
package arith_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} fmt_state_t;

  localparam int LED_DIV0 = 0;
  localparam int LED_SIGN = 1;
  localparam int LED_ZERO = 2;

endpackage

// File: rtl/seg7_decoder.sv
// BCD nibble to active-low seven-segment pattern; non-decimal codes go dark.
module seg7_decoder
  import arith_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup from digit value to segment pattern
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/result_display_formatter.sv
// Converts each accepted result magnitude to BCD with a bit-serial double-dabble
// engine, then registers the three digit patterns and status LEDs in one step.
// A one-entry pending slot lets a new result arrive while a conversion runs.
module result_display_formatter
  import arith_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mag,
  input  logic             in_neg,
  input  logic             in_div0,
  output logic [6:0]       hex_ones,
  output logic [6:0]       hex_tens,
  output logic [6:0]       hex_hund,
  output logic [2:0]       led_status,
  output logic             done
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(WIDTH + 1);

  fmt_state_t         state, state_nxt;
  logic [ITER_W-1:0]  iter;
  logic [BCD_W-1:0]   bcd, bcd_adj;
  logic [WIDTH-1:0]   bin, cur_mag, pend_mag;
  logic               cur_neg, cur_div0, pend_neg, pend_div0, pend_full;
  logic               load_in, load_pend, do_shift, do_commit, pend_fill;
  logic [6:0]         seg_h, seg_t, seg_o, disp_h, disp_t, disp_o;
  logic [2:0]         led_nxt;
  logic               hund_zero, tens_zero, mag_zero, show_sign;

  // Add 3 to every nibble of 5 or more so the following left shift carries correctly
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign bcd_adj  = dd_adjust(bcd);
  assign in_ready = (state == IDLE) || !pend_full;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a commit chains straight into another conversion when work is waiting
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (iter == ITER_W'(WIDTH - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = (pend_full || in_valid) ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control strobes; a full slot has priority over the input at commit
  always_comb begin
    load_in   = 1'b0;
    load_pend = 1'b0;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    pend_fill = 1'b0;
    case (state)
      IDLE:  load_in = in_valid;
      SHIFT: begin
        do_shift  = 1'b1;
        pend_fill = in_valid && in_ready;
      end
      COMMIT: begin
        do_commit = 1'b1;
        load_pend = pend_full;
        load_in   = !pend_full && in_valid;
      end
      default: ;
    endcase
  end

  // Conversion control: iteration count and pending-slot occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter      <= '0;
      pend_full <= 1'b0;
    end else begin
      if (load_in || load_pend) iter <= '0;
      else if (do_shift)        iter <= iter + ITER_W'(1);
      if (pend_fill)      pend_full <= 1'b1;
      else if (load_pend) pend_full <= 1'b0;
    end
  end

  // Double-dabble datapath and captured operands (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (load_in) begin
      bin      <= in_mag;
      bcd      <= '0;
      cur_mag  <= in_mag;
      cur_neg  <= in_neg;
      cur_div0 <= in_div0;
    end else if (load_pend) begin
      bin      <= pend_mag;
      bcd      <= '0;
      cur_mag  <= pend_mag;
      cur_neg  <= pend_neg;
      cur_div0 <= pend_div0;
    end else if (do_shift) begin
      {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
    end
    if (pend_fill) begin
      pend_mag  <= in_mag;
      pend_neg  <= in_neg;
      pend_div0 <= in_div0;
    end
  end

  seg7_decoder u_dec_hund (.bcd(bcd[11:8]), .seg(seg_h));
  seg7_decoder u_dec_tens (.bcd(bcd[7:4]),  .seg(seg_t));
  seg7_decoder u_dec_ones (.bcd(bcd[3:0]),  .seg(seg_o));

  assign hund_zero = (bcd[11:8] == 4'd0);
  assign tens_zero = (bcd[7:4] == 4'd0);
  assign mag_zero  = (cur_mag == '0);
  assign show_sign = cur_neg && !mag_zero;

  // Leading-zero blanking, minus placement and error override on the decoded digits
  always_comb begin
    disp_h = seg_h;
    disp_t = seg_t;
    disp_o = seg_o;
    if (BLANK_LEADING != 0) begin
      if (hund_zero)              disp_h = SEG_OFF;
      if (hund_zero && tens_zero) disp_t = SEG_OFF;
      if (show_sign) begin
        if (hund_zero && tens_zero) disp_t = SEG_MINUS;
        else if (hund_zero)         disp_h = SEG_MINUS;
      end
    end
    if (cur_div0) begin
      disp_h = SEG_E;
      disp_t = SEG_R;
      disp_o = SEG_R;
    end
    led_nxt           = '0;
    led_nxt[LED_DIV0] = cur_div0;
    led_nxt[LED_SIGN] = show_sign;
    led_nxt[LED_ZERO] = mag_zero && !cur_div0;
  end

  // Display registers change only at commit; done marks that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_hund   <= SEG_OFF;
      hex_tens   <= SEG_OFF;
      hex_ones   <= SEG_OFF;
      led_status <= '0;
      done       <= 1'b0;
    end else begin
      done <= do_commit;
      if (do_commit) begin
        hex_hund   <= disp_h;
        hex_tens   <= disp_t;
        hex_ones   <= disp_o;
        led_status <= led_nxt;
      end
    end
  end

endmodule
